// File: rtl/fuzz_sig_pkg.sv
// Shared types and constants for the fuzz signature compactor.
//   state_e      : compactor FSM states (2-bit encoding)
//   DEFAULT_POLY : MISR feedback polynomial (CRC-32 polynomial)
//   DEFAULT_SEED : signature value loaded on start and on reset
package fuzz_sig_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;
  localparam logic [31:0] DEFAULT_SEED = 32'hFFFFFFFF;

endpackage

// File: rtl/fuzz_sig_compactor_misr_update.sv
// One combinational MISR step.
//   sig_i : current signature (SIG_W)
//   y_i   : sampled word, zero-extended to SIG_W before folding in (Y_W)
//   sig_o : next signature = shift-left, conditional POLY feedback, XOR sample
module misr_update #(
  parameter int unsigned        Y_W   = 10,
  parameter int unsigned        SIG_W = 32,
  parameter logic [SIG_W-1:0]   POLY  = SIG_W'(32'h04C11DB7)
) (
  input  logic [SIG_W-1:0] sig_i,
  input  logic [Y_W-1:0]   y_i,
  output logic [SIG_W-1:0] sig_o
);

  always_comb begin
    sig_o = {sig_i[SIG_W-2:0], 1'b0};
    if (sig_i[SIG_W-1]) begin
      sig_o = sig_o ^ POLY;
    end
    sig_o = sig_o ^ SIG_W'(y_i);
  end

endmodule

// File: rtl/fuzz_sig_compactor.sv
// Compresses the fuzz DUT's y output into a MISR signature over a programmed
// number of cycles and offers the result on a valid/ready port.
//   clk        : clock, all logic on posedge
//   rst        : synchronous reset, active-high
//   start      : begin a run (sampled only in IDLE)
//   num_cycles : samples to absorb, captured with start
//   y_in       : DUT output, absorbed once per RUN cycle
//   busy       : high while in RUN
//   sig_valid  : signature available (HOLD)
//   sig_ready  : consumer accepts signature
//   signature  : MISR value, stable while sig_valid
//   samples    : samples absorbed in current/last run
// All outputs come straight from flops.
module fuzz_sig_compactor
  import fuzz_sig_pkg::*;
#(
  parameter int unsigned      Y_W   = 10,
  parameter int unsigned      SIG_W = 32,
  parameter int unsigned      CNT_W = 16,
  parameter logic [SIG_W-1:0] POLY  = SIG_W'(DEFAULT_POLY),
  parameter logic [SIG_W-1:0] SEED  = SIG_W'(DEFAULT_SEED)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_cycles,
  input  logic [Y_W-1:0]   y_in,
  output logic             busy,
  output logic             sig_valid,
  input  logic             sig_ready,
  output logic [SIG_W-1:0] signature,
  output logic [CNT_W-1:0] samples
);

  state_e             state_q;
  logic               busy_q;
  logic               valid_q;
  logic [SIG_W-1:0]   sig_q;
  logic [SIG_W-1:0]   sig_d;
  logic [CNT_W-1:0]   samples_q;
  logic [CNT_W-1:0]   remaining_q;

  misr_update #(
    .Y_W   (Y_W),
    .SIG_W (SIG_W),
    .POLY  (POLY)
  ) u_misr (
    .sig_i (sig_q),
    .y_i   (y_in),
    .sig_o (sig_d)
  );

  // busy/valid are registered alongside the state so they track it exactly
  // without a decode stage on the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      sig_q       <= SEED;
      samples_q   <= '0;
      remaining_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            sig_q     <= SEED;
            samples_q <= '0;
            if (num_cycles != '0) begin
              remaining_q <= num_cycles;
              state_q     <= RUN;
              busy_q      <= 1'b1;
            end else begin
              state_q <= HOLD;
              valid_q <= 1'b1;
            end
          end
        end
        RUN: begin
          sig_q       <= sig_d;
          samples_q   <= samples_q + 1'b1;
          remaining_q <= remaining_q - 1'b1;
          if (remaining_q == CNT_W'(1)) begin
            state_q <= HOLD;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end
        end
        HOLD: begin
          if (sig_ready) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign sig_valid = valid_q;
  assign signature = sig_q;
  assign samples   = samples_q;

endmodule
